// File: rtl/mystic_pkg.sv
// Shared types and constants for the mystic fetch stage.
package mystic_pkg;

  // One-hot so each state decode is a single flop bit.
  typedef enum logic [3:0] {
    S_FETCH = 4'b0001,
    S_WAIT  = 4'b0010,
    S_KILL  = 4'b0100,
    S_HOLD  = 4'b1000
  } fetch_state_t;

  localparam int          ILEN_C        = 2;
  localparam int          ILEN_32       = 4;
  localparam logic [31:0] BOOT_ADDR_DEF = 32'h0000_0000;

endpackage

// File: rtl/mystic_fetch_if.sv
// Fetch-stage bundle: control from execute, the memory instruction port and the decode handshake.
interface mystic_fetch_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  core_en_i;
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;
  logic                  mem_free_i;
  logic                  mem_rd_instr_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_ready_i;
  logic [31:0]           mem_instr_i;
  logic                  mem_is_compressed_i;
  logic                  instr_valid_o;
  logic [31:0]           instr_o;
  logic [ADDR_WIDTH-1:0] instr_pc_o;
  logic                  instr_compressed_o;
  logic                  instr_ready_i;

  modport master (
    input  core_en_i, redirect_i, redirect_pc_i, mem_free_i,
    input  mem_ready_i, mem_instr_i, mem_is_compressed_i, instr_ready_i,
    output mem_rd_instr_o, mem_addr_o,
    output instr_valid_o, instr_o, instr_pc_o, instr_compressed_o
  );

  modport slave (
    output core_en_i, redirect_i, redirect_pc_i, mem_free_i,
    output mem_ready_i, mem_instr_i, mem_is_compressed_i, instr_ready_i,
    input  mem_rd_instr_o, mem_addr_o,
    input  instr_valid_o, instr_o, instr_pc_o, instr_compressed_o
  );
endinterface

// File: rtl/mystic_fetch.sv
// Instruction fetch: PC register plus a four-state FSM that issues one read at a time,
// buffers one instruction for decode and squashes in-flight reads on redirect.
module mystic_fetch
  import mystic_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = BOOT_ADDR_DEF[ADDR_WIDTH-1:0]
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mystic_fetch_if.master bus
);

  fetch_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic                  r_mem_rd;
  logic                  r_valid;
  logic                  r_comp;
  logic [31:0]           r_instr;

  logic [ADDR_WIDTH-1:0] w_redir_pc;
  logic [ADDR_WIDTH-1:0] w_ilen;

  // Targets are halfword aligned; bit 0 is dropped rather than trapped.
  assign w_redir_pc = {bus.redirect_pc_i[ADDR_WIDTH-1:1], 1'b0};
  assign w_ilen     = bus.mem_is_compressed_i ? ADDR_WIDTH'(ILEN_C) : ADDR_WIDTH'(ILEN_32);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_FETCH;
      r_pc       <= BOOT_ADDR;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_comp     <= 1'b0;
    end else if (!bus.core_en_i) begin
      // Memory idles while disabled, so nothing is left outstanding; the address just holds.
      r_state    <= S_FETCH;
      r_pc       <= BOOT_ADDR;
      r_mem_rd   <= 1'b0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_comp     <= 1'b0;
    end else begin
      r_mem_rd <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (bus.redirect_i) begin
            r_pc <= w_redir_pc;
          end else if (bus.mem_free_i) begin
            r_mem_rd   <= 1'b1;
            r_mem_addr <= r_pc;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.redirect_i) begin
            r_pc    <= w_redir_pc;
            r_state <= bus.mem_ready_i ? S_FETCH : S_KILL;
          end else if (bus.mem_ready_i) begin
            r_instr    <= bus.mem_instr_i;
            r_instr_pc <= r_mem_addr;
            r_comp     <= bus.mem_is_compressed_i;
            r_valid    <= 1'b1;
            r_pc       <= r_pc + w_ilen;
            r_state    <= S_HOLD;
          end
        end
        S_KILL: begin
          if (bus.redirect_i) r_pc <= w_redir_pc;
          if (bus.mem_ready_i) r_state <= S_FETCH;
        end
        S_HOLD: begin
          // Redirect beats a same-cycle accept: the held instruction is not transferred.
          if (bus.redirect_i) begin
            r_valid <= 1'b0;
            r_pc    <= w_redir_pc;
            r_state <= S_FETCH;
          end else if (bus.instr_ready_i) begin
            r_valid <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign bus.mem_rd_instr_o     = r_mem_rd;
  assign bus.mem_addr_o         = r_mem_addr;
  assign bus.instr_valid_o      = r_valid;
  assign bus.instr_o            = r_instr;
  assign bus.instr_pc_o         = r_instr_pc;
  assign bus.instr_compressed_o = r_comp;

endmodule

// File: tb/tb_mystic_fetch.sv
// Randomised and directed bench for mystic_fetch against a flag-based transaction model.
module tb_mystic_fetch;
  import mystic_pkg::*;

  localparam logic [31:0] BOOT = BOOT_ADDR_DEF;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  mystic_fetch_if #(.ADDR_WIDTH(32)) b();

  mystic_fetch #(.ADDR_WIDTH(32), .BOOT_ADDR(BOOT)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory image: parity of addr[4:1] selects 16-bit encodings.
  function automatic logic [32:0] memf(input logic [31:0] a);
    logic c;
    c = ^a[4:1];
    if (c) return {1'b1, 16'h0, 16'h4505 ^ (a[15:0] & 16'hFFF0)};
    return {1'b0, 32'h0050_0093 ^ (a & 32'hFFFF_FFF0)};
  endfunction

  // Model: what the fetch stage must show after each edge.
  logic [31:0] m_pc, m_addr, m_instr, m_ipc;
  logic        m_rd, m_valid, m_comp;
  logic        m_busy, m_kill;

  // Memory side: one pending request with a countdown.
  logic        pend = 1'b0;
  int          cnt = 0;
  int          lat = 1;
  logic [31:0] paddr = '0;

  int   vrises = 0;
  int   xfers = 0;
  logic prev_valid = 1'b0;

  task automatic model_reset(input logic keep_addr);
    m_pc = BOOT; m_rd = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_comp = 0;
    m_busy = 0; m_kill = 0;
    if (!keep_addr) m_addr = 0;
  endtask

  task automatic model_step(input logic en, input logic redir, input logic [31:0] tgt,
                            input logic free, input logic mrdy, input logic [31:0] minstr,
                            input logic mcomp, input logic drdy);
    logic [31:0] t;
    t = {tgt[31:1], 1'b0};
    if (!en) begin
      model_reset(1'b1);
      return;
    end
    m_rd = 0;
    if (m_valid) begin
      if (redir) begin m_valid = 0; m_pc = t; end
      else if (drdy) m_valid = 0;
    end else if (m_busy) begin
      if (redir) begin
        m_pc = t; m_busy = 0; m_kill = !mrdy;
      end else if (mrdy) begin
        m_instr = minstr; m_ipc = m_addr; m_comp = mcomp; m_valid = 1;
        m_pc = m_pc + (mcomp ? 32'd2 : 32'd4); m_busy = 0;
      end
    end else if (m_kill) begin
      if (redir) m_pc = t;
      if (mrdy) m_kill = 0;
    end else begin
      if (redir) m_pc = t;
      else if (free) begin m_rd = 1; m_addr = m_pc; m_busy = 1; end
    end
  endtask

  task automatic compare_all();
    logic [32:0] md;
    chk("rd",    32'(b.mem_rd_instr_o),     32'(m_rd));
    chk("addr",  b.mem_addr_o,              m_addr);
    chk("valid", 32'(b.instr_valid_o),      32'(m_valid));
    chk("instr", b.instr_o,                 m_instr);
    chk("ipc",   b.instr_pc_o,              m_ipc);
    chk("comp",  32'(b.instr_compressed_o), 32'(m_comp));
    if (b.instr_valid_o && !prev_valid) begin
      vrises++;
      md = memf(b.instr_pc_o);
      chk("sb_instr", b.instr_o, md[31:0]);
      chk("sb_comp", 32'(b.instr_compressed_o), 32'(md[32]));
    end
    prev_valid = b.instr_valid_o;
  endtask

  task automatic cyc(input logic en, input logic redir, input logic [31:0] tgt,
                     input logic free, input logic drdy);
    logic        mrdy;
    logic [32:0] md;
    if (b.mem_rd_instr_o) begin pend = 1; cnt = lat; paddr = b.mem_addr_o; end
    mrdy = 0;
    if (!en) pend = 0;
    else if (pend) begin
      if (cnt == 0) begin mrdy = 1; pend = 0; end
      else cnt--;
    end
    md = memf(paddr);
    if (mrdy) assert (m_busy || m_kill) else $error("memory response with no read outstanding");
    if (en && drdy && !redir && b.instr_valid_o) xfers++;
    b.core_en_i = en; b.redirect_i = redir; b.redirect_pc_i = tgt; b.mem_free_i = free;
    b.mem_ready_i = mrdy; b.mem_instr_i = mrdy ? md[31:0] : $urandom;
    b.mem_is_compressed_i = mrdy ? md[32] : 1'($urandom);
    b.instr_ready_i = drdy;
    model_step(en, redir, tgt, free, mrdy, md[31:0], md[32], drdy);
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic do_reset();
    rst_i = 1;
    b.core_en_i = 1; b.redirect_i = 0; b.redirect_pc_i = '0; b.mem_free_i = 0;
    b.mem_ready_i = 0; b.mem_instr_i = '0; b.mem_is_compressed_i = 0; b.instr_ready_i = 0;
    pend = 0;
    model_reset(1'b0);
    @(negedge clk_i);
    compare_all();
    rst_i = 0;
  endtask

  task automatic wait_for(input string tag, input bit want_valid, input int budget,
                          input logic free, input logic drdy);
    logic found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      cyc(1, 0, '0, free, drdy);
      found = want_valid ? b.instr_valid_o : b.mem_rd_instr_o;
    end
    chk({tag, "_seen"}, 32'(found), 32'(1'b1));
  endtask

  int          v0, x0;
  logic [31:0] snap;

  initial begin
    do_reset();

    // Basic uncompressed fetch from boot.
    lat = 1;
    wait_for("p1_req", 0, 10, 1, 1);
    chk("p1_addr", b.mem_addr_o, 32'h0);
    wait_for("p1_val", 1, 10, 1, 1);
    chk("p1_instr", b.instr_o, 32'h0050_0093);
    chk("p1_ipc", b.instr_pc_o, 32'h0);
    wait_for("p1_req2", 0, 10, 1, 1);
    chk("p1_next", b.mem_addr_o, 32'h4);

    // Compressed instruction advances by 2.
    do_reset();
    cyc(1, 1, 32'h8, 1, 1);
    wait_for("p2_req", 0, 10, 1, 1);
    chk("p2_addr", b.mem_addr_o, 32'h8);
    wait_for("p2_val", 1, 10, 1, 1);
    chk("p2_comp", 32'(b.instr_compressed_o), 32'(1'b1));
    chk("p2_instr", b.instr_o, 32'h0000_4505);
    wait_for("p2_req2", 0, 10, 1, 1);
    chk("p2_next", b.mem_addr_o, 32'hA);

    // Redirect while waiting squashes the response.
    do_reset();
    lat = 2;
    wait_for("p3_req", 0, 10, 1, 1);
    cyc(1, 1, 32'h101, 1, 1);
    v0 = vrises;
    wait_for("p3_req2", 0, 10, 1, 1);
    chk("p3_addr", b.mem_addr_o, 32'h100);
    chk("p3_norise", 32'(vrises - v0), 32'h0);

    // Redirect beats a same-cycle accept in hold.
    do_reset();
    lat = 1;
    cyc(1, 1, 32'h20, 1, 0);
    wait_for("p4_val", 1, 10, 1, 0);
    chk("p4_ipc", b.instr_pc_o, 32'h20);
    x0 = xfers;
    cyc(1, 1, 32'h40, 1, 1);
    chk("p4_valid", 32'(b.instr_valid_o), 32'(1'b0));
    chk("p4_xfer", 32'(xfers - x0), 32'h0);
    wait_for("p4_req", 0, 10, 1, 1);
    chk("p4_addr", b.mem_addr_o, 32'h40);

    // Decode backpressure.
    do_reset();
    lat = 0;
    wait_for("p5_val", 1, 10, 1, 0);
    snap = b.instr_o;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, '0, 1, 0);
      chk("p5_stable", b.instr_o, snap);
      chk("p5_norq", 32'(b.mem_rd_instr_o), 32'(1'b0));
    end
    cyc(1, 0, '0, 1, 1);
    chk("p5_acc_rd", 32'(b.mem_rd_instr_o), 32'(1'b0));
    cyc(1, 0, '0, 1, 1);
    chk("p5_rd", 32'(b.mem_rd_instr_o), 32'(1'b1));
    chk("p5_addr", b.mem_addr_o, 32'h4);

    // Core disable mid-wait, then mem_free_i holding off the restart.
    do_reset();
    lat = 3;
    cyc(1, 1, 32'h30, 1, 1);
    wait_for("p6_req", 0, 10, 1, 1);
    chk("p6_addr", b.mem_addr_o, 32'h30);
    v0 = vrises;
    cyc(0, 0, '0, 1, 1);
    chk("p6_hold", b.mem_addr_o, 32'h30);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, '0, 0, 1);
      chk("p6_off", 32'(b.mem_rd_instr_o), 32'(1'b0));
    end
    wait_for("p6_req2", 0, 10, 1, 1);
    chk("p6_boot", b.mem_addr_o, BOOT);
    chk("p6_norise", 32'(vrises - v0), 32'h0);

    // PC wrap and target bit 0 forced low.
    do_reset();
    lat = 1;
    cyc(1, 1, 32'hFFFF_FFFF, 1, 1);
    wait_for("p7_req", 0, 10, 1, 1);
    chk("p7_addr", b.mem_addr_o, 32'hFFFF_FFFE);
    wait_for("p7_val", 1, 10, 1, 1);
    wait_for("p7_req2", 0, 10, 1, 1);
    chk("p7_wrap", b.mem_addr_o, 32'h2);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) do_reset();
      else begin
        lat = int'($urandom_range(3));
        cyc($urandom_range(19) != 0, $urandom_range(9) == 0, $urandom,
            $urandom_range(9) < 7, $urandom_range(9) < 6);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
